// File: rtl/kv_cache_sched.sv
// rtl/kv_cache_sched.sv - write/read-burst scheduler and arbiter for the shared K/V cache pair
// KV_RING_EN: sliding-window mode; writes while full overwrite the oldest token and advance head.
module kv_cache_sched #(
  parameter int MAX_SEQ_LEN = 2048,
  parameter int HEADS       = 12,
  parameter int DW          = 4,
  parameter int AW          = $clog2(MAX_SEQ_LEN),
  parameter int RW          = HEADS * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_k,
  input  logic [RW-1:0] wr_v,
  input  logic          rd_req,
  output logic          rd_busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [RW-1:0] rd_k,
  output logic [RW-1:0] rd_v,
  output logic [AW-1:0] rd_idx,
  output logic          rd_last,
  output logic          rd_done,
  output logic [AW:0]   seq_len,
  output logic          full,
  output logic          ovf,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [RW-1:0] mem_kdin,
  output logic [RW-1:0] mem_vdin,
  input  logic [RW-1:0] mem_kdout,
  input  logic [RW-1:0] mem_vdout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_SEQ_LEN);

  logic [1:0]    state;
  logic [AW-1:0] head;
  logic [AW:0]   burst_len;
  logic [AW:0]   issue_cnt;
  logic [AW:0]   push_cnt;
  logic          last_wr;
  logic          ret_v;
  logic [RW-1:0] fifo_k [3];
  logic [RW-1:0] fifo_v [3];
  logic [AW-1:0] fifo_i [3];
  logic [1:0]    wptr, rptr, fcnt;
  logic          wr_ok, grant_w, grant_r, pop, can_issue;
  logic [2:0]    occ;
  logic [AW-1:0] tail_addr, rd_addr;

  function automatic logic [AW-1:0] wrap(input logic [AW:0] a);
    return (a >= MAX_LEN) ? AW'(a - MAX_LEN) : AW'(a);
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign full = (seq_len == MAX_LEN);
`ifdef KV_RING_EN
  assign wr_ok = wr_valid;
`else
  assign wr_ok = wr_valid && !full;
`endif
  // Writer wins contention unless it also took the previous grant.
  assign grant_w  = rst && !clr && (state == S_IDLE) && wr_ok && (!rd_req || !last_wr);
  assign grant_r  = rst && !clr && (state == S_IDLE) && rd_req && !grant_w;
  assign wr_ready = grant_w;

  assign tail_addr = wrap({1'b0, head} + seq_len);
  assign rd_addr   = wrap({1'b0, head} + issue_cnt);

  assign rd_valid = (fcnt != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign rd_k     = rd_valid ? fifo_k[rptr] : '0;
  assign rd_v     = rd_valid ? fifo_v[rptr] : '0;
  assign rd_idx   = rd_valid ? fifo_i[rptr] : '0;
  assign rd_last  = rd_valid && ({1'b0, fifo_i[rptr]} == burst_len - 1'b1);

  // Reads in flight plus buffered beats never exceed the 3-entry buffer; a pop this cycle frees a slot.
  assign occ       = {1'b0, fcnt} + {2'b0, ret_v} + {2'b0, mem_re};
  assign can_issue = (state == S_READ) && (occ < 3'd3 + {2'b0, pop});

  always_ff @(posedge clk) begin
    if (ret_v) begin
      fifo_k[wptr] <= mem_kdout;
      fifo_v[wptr] <= mem_vdout;
      fifo_i[wptr] <= push_cnt[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state     <= S_IDLE;
      seq_len   <= '0;
      head      <= '0;
      ovf       <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      fcnt      <= '0;
      ret_v     <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      burst_len <= '0;
      issue_cnt <= '0;
      push_cnt  <= '0;
      if (!rst) begin
        last_wr  <= 1'b0;
        mem_addr <= '0;
        mem_kdin <= '0;
        mem_vdin <= '0;
      end
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_done <= 1'b0;
      ret_v   <= mem_re;
      if (ret_v) begin
        wptr     <= ptr_inc(wptr);
        push_cnt <= push_cnt + 1'b1;
      end
      if (pop) rptr <= ptr_inc(rptr);
      fcnt <= fcnt + {1'b0, ret_v} - {1'b0, pop};
`ifndef KV_RING_EN
      if (wr_valid && full) ovf <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (grant_w) begin
            mem_we   <= 1'b1;
            mem_addr <= tail_addr;
            mem_kdin <= wr_k;
            mem_vdin <= wr_v;
            last_wr  <= 1'b1;
            state    <= S_WRITE;
`ifdef KV_RING_EN
            if (full) head <= wrap({1'b0, head} + 1'b1);
            else      seq_len <= seq_len + 1'b1;
`else
            seq_len <= seq_len + 1'b1;
`endif
          end else if (grant_r) begin
            last_wr   <= 1'b0;
            burst_len <= seq_len;
            push_cnt  <= '0;
            if (seq_len == '0) begin
              rd_done <= 1'b1;
            end else begin
              mem_re    <= 1'b1;
              mem_addr  <= head;
              issue_cnt <= (AW+1)'(1);
              rd_busy   <= 1'b1;
              state     <= (seq_len == (AW+1)'(1)) ? S_DRAIN : S_READ;
            end
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ: begin
          if (can_issue) begin
            mem_re    <= 1'b1;
            mem_addr  <= rd_addr;
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt + 1'b1 == burst_len) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && rd_last) begin
            rd_done <= 1'b1;
            rd_busy <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kv_cache_sched.sv
// tb/tb_kv_cache_sched.sv - scoreboard bench for kv_cache_sched with a behavioural K/V cache model
module tb_kv_cache_sched;
  localparam int MAX = 2048;
  localparam int AW  = 11;
  localparam int RW  = 48;

  logic          clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic          wr_valid = 1'b0, rd_req = 1'b0, rd_ready = 1'b1;
  logic [RW-1:0] wr_k = '0, wr_v = '0, mem_kdout = '0, mem_vdout = '0;
  logic          wr_ready, rd_busy, rd_valid, rd_last, rd_done, full, ovf, mem_we, mem_re;
  logic [RW-1:0] rd_k, rd_v, mem_kdin, mem_vdin;
  logic [AW-1:0] rd_idx, mem_addr;
  logic [AW:0]   seq_len;

  kv_cache_sched #(.MAX_SEQ_LEN(MAX), .HEADS(12), .DW(4), .AW(AW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_k(wr_k), .wr_v(wr_v),
    .rd_req(rd_req), .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_k(rd_k), .rd_v(rd_v), .rd_idx(rd_idx), .rd_last(rd_last), .rd_done(rd_done),
    .seq_len(seq_len), .full(full), .ovf(ovf),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_kdin(mem_kdin), .mem_vdin(mem_vdin), .mem_kdout(mem_kdout), .mem_vdout(mem_vdout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RW-1:0] kmem [MAX];
  logic [RW-1:0] vmem [MAX];
  always @(posedge clk) begin
    if (mem_we) begin
      kmem[mem_addr] <= mem_kdin;
      vmem[mem_addr] <= mem_vdin;
    end
    if (mem_re) begin
      mem_kdout <= kmem[mem_addr];
      mem_vdout <= vmem[mem_addr];
    end
  end

  int n_vec = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [RW-1:0] k;
    logic [RW-1:0] v;
    logic          last;
  } beat_t;

  beat_t         sb [$];
  logic [RW-1:0] mk [$];
  logic [RW-1:0] mv [$];

  task automatic model_write(input logic [RW-1:0] k, input logic [RW-1:0] v);
    if (mk.size() == MAX) begin
      void'(mk.pop_front());
      void'(mv.pop_front());
    end
    mk.push_back(k);
    mv.push_back(v);
  endtask

  task automatic push_expect();
    beat_t e;
    for (int i = 0; i < mk.size(); i++) begin
      e.idx = AW'(i); e.k = mk[i]; e.v = mv[i]; e.last = (i == mk.size() - 1);
      sb.push_back(e);
    end
  endtask

  int rdy_mode = 0, rdy_ph = 0;
  logic [3:0] rdy_pat = 4'b1001;
  always @(negedge clk) begin
    if (rdy_mode == 1) begin
      rd_ready = rdy_pat[rdy_ph];
      rdy_ph = (rdy_ph + 1) % 4;
    end else begin
      rd_ready = 1'b1;
    end
  end

  int n_re = 0, n_acc = 0, n_done = 0, first_re = -1, last_re = -1, first_re_addr = -1;
  int done_cyc = -1, wr_in_busy = 0;
  int beat_cyc [$];
  int we_addr [$];
  int we_cyc [$];
  logic stalled = 1'b0;
  logic [RW-1:0] held_k;
  logic [AW-1:0] held_i;

  // Output monitor: samples mid-cycle, well clear of the active edge.
  always @(negedge clk) begin
    beat_t e;
    #2;
    if (mem_we) begin
      we_addr.push_back(int'(mem_addr));
      we_cyc.push_back(cyc);
    end
    if (mem_re) begin
      if (n_re == 0) begin
        first_re = cyc;
        first_re_addr = int'(mem_addr);
      end
      last_re = cyc;
      n_re++;
      check("occupancy_le3", (n_re - n_acc) <= 3, 1'b1);
    end
    if (stalled) begin
      check("stall_valid", rd_valid, 1'b1);
      check("stall_k", rd_k, held_k);
      check("stall_idx", rd_idx, held_i);
    end
    stalled = rd_valid && !rd_ready;
    held_k = rd_k;
    held_i = rd_idx;
    if (rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check("beat_expected", 1'b0, 1'b1);
      end else begin
        e = sb.pop_front();
        check("beat_idx", rd_idx, e.idx);
        check("beat_k", rd_k, e.k);
        check("beat_v", rd_v, e.v);
        check("beat_last", rd_last, e.last);
      end
      n_acc++;
      beat_cyc.push_back(cyc);
    end
    if (rd_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (wr_ready && rd_busy) wr_in_busy++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [RW-1:0] k, input logic [RW-1:0] v);
    int t;
    wr_valid = 1'b1; wr_k = k; wr_v = v;
    #1;
    t = 0;
    while (!wr_ready && t < 16) begin
      @(negedge clk); #1; t++;
    end
    check("wr_grant", wr_ready, 1'b1);
    if (wr_ready) model_write(k, v);
    @(negedge clk);
  endtask

  task automatic reset_burst_stats();
    n_re = 0; n_acc = 0; n_done = 0; first_re = -1; last_re = -1; first_re_addr = -1;
    done_cyc = -1;
    beat_cyc.delete();
  endtask

  // Called at a negedge with the DUT idle; the grant edge ends cycle g.
  task automatic do_burst(input int mode, output int g);
    int t;
    reset_burst_stats();
    push_expect();
    rdy_mode = mode; rdy_ph = 0;
    rd_req = 1'b1;
    g = cyc;
    t = 0;
    while (t < 8) begin
      @(negedge clk); #3; t++;
      if (rd_busy || rd_done) break;
    end
    rd_req = 1'b0;
    t = 0;
    while (n_done == 0 && t < 3 * MAX + 100) begin
      @(negedge clk); #3; t++;
    end
    check("burst_done", n_done, 1);
    check("sb_empty", sb.size(), 0);
    rdy_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g, code, row;
    int gseq [$];
    logic prev_busy, bump;

    // Reset state
    rst = 1'b0;
    idle(3);
    #3;
    check("rst_seq_len", seq_len, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_rd_k", rd_k, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    // Three writes, K=i V=~i
    we_addr.delete(); we_cyc.delete();
    for (int i = 0; i < 3; i++) do_write(RW'(i), ~RW'(i));
    wr_valid = 1'b0;
    idle(2);
    check("we_count", we_addr.size(), 3);
    for (int i = 0; i < we_addr.size() && i < 3; i++) begin
      check("we_addr", we_addr[i], i);
      if (i > 0) check("we_spacing", we_cyc[i] - we_cyc[i-1], 2);
    end
    check("seq_len_3", seq_len, 3);
    check("full_0", full, 0);

    // Burst with rd_ready held high: exact cycle timing
    do_burst(0, g);
    check("re_first", first_re, g + 1);
    check("re_last", last_re, g + 3);
    check("re_count", n_re, 3);
    check("re_addr0", first_re_addr, 0);
    check("beat_count", beat_cyc.size(), 3);
    for (int i = 0; i < beat_cyc.size() && i < 3; i++) check("beat_cycle", beat_cyc[i], g + 3 + i);
    check("done_cycle", done_cyc, g + 6);
    idle(2);

    // Same burst under 1,0,0,1 backpressure
    do_burst(1, g);
    check("stall_beats", n_acc, 3);
    check("stall_reads", n_re, 3);
    idle(2);

    // Writer and reader held together: grants alternate W, R, W
    reset_burst_stats();
    wr_in_busy = 0; prev_busy = 1'b0; bump = 1'b0; gseq.delete();
    row = 100;
    wr_k = RW'(row); wr_v = ~RW'(row); wr_valid = 1'b1; rd_req = 1'b1;
    for (int t = 0; t < 300 && gseq.size() < 3; t++) begin
      #1;
      if (wr_ready) begin
        gseq.push_back(1);
        model_write(wr_k, wr_v);
        bump = 1'b1;
        if (gseq.size() == 3) rd_req = 1'b0;
      end
      if (rd_busy && !prev_busy) begin
        gseq.push_back(0);
        push_expect();
        rd_req = 1'b0;
      end
      prev_busy = rd_busy;
      @(negedge clk);
      if (bump) begin
        row++;
        wr_k = RW'(row); wr_v = ~RW'(row);
        bump = 1'b0;
      end
      if (rd_done && gseq.size() < 3) rd_req = 1'b1;
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    idle(3);
    code = 0;
    foreach (gseq[i]) code = code * 2 + gseq[i];
    check("grant_count", gseq.size(), 3);
    check("grant_order_wrw", code, 5);
    check("wr_ready_in_burst", wr_in_busy, 0);
    check("arb_sb_empty", sb.size(), 0);
    check("arb_seq_len", seq_len, 5);

    // clr after the first beat of a burst
    reset_burst_stats();
    push_expect();
    rd_req = 1'b1;
    for (int t = 0; t < 20 && n_acc < 1; t++) begin
      @(negedge clk); #3;
      if (rd_busy) rd_req = 1'b0;
    end
    rd_req = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sb.delete(); mk.delete(); mv.delete();
    #3;
    check("clr_rd_valid", rd_valid, 0);
    check("clr_seq_len", seq_len, 0);
    check("clr_rd_busy", rd_busy, 0);
    idle(6);
    check("clr_no_done", n_done, 0);
    check("clr_beats", n_acc, 1);
    do_burst(0, g);
    check("empty_done_cycle", done_cyc, g + 1);
    check("empty_beats", n_acc, 0);
    check("empty_reads", n_re, 0);
    idle(2);

    // Fill to capacity
    for (int i = 0; i < MAX; i++) do_write(RW'(i * 3 + 1), ~RW'(i));
    wr_valid = 1'b0;
    idle(2);
    check("fill_seq_len", seq_len, MAX);
    check("fill_full", full, 1);
    check("fill_ovf", ovf, 0);
`ifdef KV_RING_EN
    we_addr.delete();
    do_write(RW'(48'h1234_5678_9abc), RW'(48'hfeed_0000_beef));
    wr_valid = 1'b0;
    idle(2);
    check("ring_we_count", we_addr.size(), 1);
    if (we_addr.size() > 0) check("ring_we_addr", we_addr[0], 0);
    check("ring_seq_len", seq_len, MAX);
    check("ring_ovf", ovf, 0);
    do_burst(0, g);
    check("ring_first_addr", first_re_addr, 1);
    check("ring_beats", n_acc, MAX);
`else
    we_addr.delete();
    wr_valid = 1'b1; wr_k = RW'(7); wr_v = RW'(8);
    #1;
    check("ovf_wr_ready", wr_ready, 0);
    idle(3);
    wr_valid = 1'b0;
    idle(1);
    check("ovf_set", ovf, 1);
    check("ovf_no_write", we_addr.size(), 0);
    check("ovf_seq_len", seq_len, MAX);
    do_burst(0, g);
    check("full_first_addr", first_re_addr, 0);
    check("full_beats", n_acc, MAX);
    check("ovf_sticky", ovf, 1);
    idle(1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mk.delete(); mv.delete();
    #3;
    check("clr_ovf", ovf, 0);
    check("clr_full", full, 0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
